uart_tx: RTL and testbench



---
 rtl/uart_tx.sv | 169 ++++++++++++++++
 tb/tb_uart_tx.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// AXI4-Stream to UART serialiser: start bit, DATA_WIDTH data bits LSB first, optional parity, 1 or 2 stop bits.
// Define UART_TX_PARITY_EN to add the parity_mode input and the parity bit; bit period = prescale*8 clk cycles.
module uart_tx #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] input_axis_tdata,
    input  logic                  input_axis_tvalid,
    output logic                  input_axis_tready,
    output logic                  txd,
    output logic                  busy,
    input  logic [15:0]           prescale,
`ifdef UART_TX_PARITY_EN
    input  logic [1:0]            parity_mode,
`endif
    input  logic                  two_stop
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    localparam logic [3:0] LAST_BIT = 4'(DATA_WIDTH - 1);

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [3:0]            r_bit_cnt;
    logic [18:0]           r_cnt;
    logic [18:0]           r_period;
    logic                  r_two_stop;
    logic                  r_txd;
    logic                  r_tready;
    logic                  r_busy;
`ifdef UART_TX_PARITY_EN
    logic                  r_par_en;
    logic                  r_par_bit;
    logic                  w_par_en;
    logic                  w_par_bit;
`endif
    logic [15:0]           w_p;
    logic [18:0]           w_period;
    logic                  w_accept;

    // 19-bit reload of 8*P-1 keeps P=0xFFFF in range; P=0 runs as P=1
    assign w_p      = (prescale == 16'd0) ? 16'd1 : prescale;
    assign w_period = {w_p, 3'b000} - 19'd1;
    assign w_accept = input_axis_tvalid && r_tready;

`ifdef UART_TX_PARITY_EN
    assign w_par_en  = (parity_mode == 2'b01) || (parity_mode == 2'b10);
    assign w_par_bit = (^input_axis_tdata) ^ (parity_mode == 2'b10);
`endif

    assign input_axis_tready = r_tready;
    assign txd               = r_txd;
    assign busy              = r_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_cnt      <= '0;
            r_period   <= '0;
            r_two_stop <= 1'b0;
            r_txd      <= 1'b1;
            r_tready   <= 1'b0;
            r_busy     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_par_en   <= 1'b0;
            r_par_bit  <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_tready <= 1'b1;
                    if (w_accept) begin
                        r_shift    <= input_axis_tdata;
                        r_two_stop <= two_stop;
                        r_period   <= w_period;
                        r_cnt      <= w_period;
                        r_bit_cnt  <= '0;
                        r_txd      <= 1'b0;
                        r_busy     <= 1'b1;
                        r_tready   <= 1'b0;
`ifdef UART_TX_PARITY_EN
                        r_par_en   <= w_par_en;
                        r_par_bit  <= w_par_bit;
`endif
                        r_state    <= S_START;
                    end
                end
                S_START: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 19'd1;
                    end else begin
                        r_cnt     <= r_period;
                        r_txd     <= r_shift[0];
                        r_shift   <= r_shift >> 1;
                        r_bit_cnt <= '0;
                        r_state   <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 19'd1;
                    end else begin
                        r_cnt <= r_period;
                        if (r_bit_cnt == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                            if (r_par_en) begin
                                r_txd   <= r_par_bit;
                                r_state <= S_PARITY;
                            end else
`endif
                            begin
                                r_txd     <= 1'b1;
                                r_bit_cnt <= {3'b000, r_two_stop};
                                r_state   <= S_STOP;
                            end
                        end else begin
                            r_txd     <= r_shift[0];
                            r_shift   <= r_shift >> 1;
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 19'd1;
                    end else begin
                        r_cnt     <= r_period;
                        r_txd     <= 1'b1;
                        r_bit_cnt <= {3'b000, r_two_stop};
                        r_state   <= S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    // bit counter holds the number of extra stop periods still owed
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 19'd1;
                    end else if (r_bit_cnt != '0) begin
                        r_bit_cnt <= r_bit_cnt - 4'd1;
                        r_cnt     <= r_period;
                    end else begin
                        r_busy   <= 1'b0;
                        r_tready <= 1'b1;
                        r_state  <= S_IDLE;
                    end
                end
                default: begin
                    r_txd   <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Randomised self-checking bench for uart_tx against a bit-list frame model.
// Build with UART_TX_PARITY_EN defined to also exercise the parity bit.
module tb_uart_tx;

    localparam int DW = 8;
`ifdef UART_TX_PARITY_EN
    localparam bit PARITY_BUILT = 1'b1;
`else
    localparam bit PARITY_BUILT = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] tdata;
    logic          tvalid;
    logic          tready;
    logic          txd;
    logic          busy;
    logic [15:0]   prescale;
    logic          two_stop;
`ifdef UART_TX_PARITY_EN
    logic [1:0]    parity_mode;
`endif

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    uart_tx #(.DATA_WIDTH(DW)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .input_axis_tdata  (tdata),
        .input_axis_tvalid (tvalid),
        .input_axis_tready (tready),
        .txd               (txd),
        .busy              (busy),
        .prescale          (prescale),
`ifdef UART_TX_PARITY_EN
        .parity_mode       (parity_mode),
`endif
        .two_stop          (two_stop)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Called at a negedge; returns at the negedge of the idle cycle after the frame.
    task automatic send(input logic [DW-1:0] word, input logic [15:0] p, input logic ts,
                        input logic [1:0] pm, input bit hold);
        int unsigned peff;
        int unsigned len;
        int unsigned waited;
        bit          q[$];
        peff = (p == 16'd0) ? 1 : int'(p);
        q.push_back(1'b0);
        for (int k = 0; k < DW; k++) q.push_back(word[k]);
        if (PARITY_BUILT && pm == 2'b01) q.push_back(^word);
        if (PARITY_BUILT && pm == 2'b10) q.push_back(~^word);
        q.push_back(1'b1);
        if (ts) q.push_back(1'b1);
        len = q.size() * 8 * peff;

        tdata    = word;
        tvalid   = 1'b1;
        prescale = p;
        two_stop = ts;
`ifdef UART_TX_PARITY_EN
        parity_mode = pm;
`endif
        waited = 0;
        while (tready !== 1'b1 && waited < 64) begin
            @(negedge clk);
            waited++;
        end
        if (tready !== 1'b1) begin
            check("accept_timeout", 32'(tready), 32'd1);
            tvalid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        // latched settings must survive arbitrary mid-frame input changes
        tdata    = DW'($urandom);
        prescale = 16'($urandom_range(0, 7));
        two_stop = 1'($urandom);
`ifdef UART_TX_PARITY_EN
        parity_mode = 2'($urandom);
`endif
        if (!hold) tvalid = 1'b0;
        for (int i = 0; i < int'(len); i++) begin
            @(negedge clk);
            check("txd", 32'(txd), 32'(q[i / (8 * peff)]));
            check("busy", 32'(busy), 32'd1);
            check("tready", 32'(tready), 32'd0);
        end
        @(negedge clk);
        check("idle_txd", 32'(txd), 32'd1);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_tready", 32'(tready), 32'd1);
    endtask

    initial begin
        rst_n    = 1'b0;
        tdata    = '0;
        tvalid   = 1'b0;
        prescale = 16'd1;
        two_stop = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_mode = 2'b00;
`endif
        #23;
        check("rst_txd", 32'(txd), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_tready", 32'(tready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_tready", 32'(tready), 32'd1);

        send(8'hA5, 16'd1, 1'b0, 2'b00, 1'b0);
        send(8'h01, 16'd0, 1'b0, 2'b00, 1'b0);
        send(8'h00, 16'd2, 1'b0, 2'b00, 1'b1);
        send(8'hFF, 16'd2, 1'b0, 2'b00, 1'b0);
        send(8'h3C, 16'd1, 1'b1, 2'b00, 1'b1);
        send(8'h96, 16'd1, 1'b0, 2'b00, 1'b0);

        // abandon a frame during data bit 3 (a 0 bit of 0x55)
        tdata    = 8'h55;
        tvalid   = 1'b1;
        prescale = 16'd1;
        two_stop = 1'b0;
        @(posedge clk);
        #1;
        tvalid = 1'b0;
        repeat (36) @(negedge clk);
        check("pre_rst_txd", 32'(txd), 32'd0);
        rst_n = 1'b0;
        #1;
        check("arst_txd", 32'(txd), 32'd1);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_tready", 32'(tready), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rerel_tready", 32'(tready), 32'd1);
        for (int i = 0; i < 24; i++) begin
            check("quiet_txd", 32'(txd), 32'd1);
            check("quiet_busy", 32'(busy), 32'd0);
            @(negedge clk);
        end
        send(8'h55, 16'd1, 1'b0, 2'b00, 1'b0);

`ifdef UART_TX_PARITY_EN
        send(8'h07, 16'd1, 1'b0, 2'b10, 1'b0);
        send(8'h07, 16'd1, 1'b0, 2'b01, 1'b0);
        send(8'h07, 16'd1, 1'b0, 2'b11, 1'b0);
`endif

        for (int n = 0; n < 24; n++) begin
            send(DW'($urandom), 16'($urandom_range(0, 3)), 1'($urandom),
                 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end
        tvalid = 1'b0;
        repeat (4) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
